// File: rtl/vga_pkg.sv
// Shared constants for the VGA write arbiter: requester indices, coordinate widths, FSM states.
package vga_pkg;

   localparam int unsigned REQ_MAP    = 0;
   localparam int unsigned REQ_ANIM   = 1;
   localparam int unsigned REQ_SPRITE = 2;
   localparam int unsigned N_REQ      = 3;

   localparam int unsigned X_W = 9;
   localparam int unsigned Y_W = 8;
   localparam int unsigned C_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/prio_pick3.sv
// Combinational fixed-priority picker: lowest requester index wins among unmasked requests.
module prio_pick3
   import vga_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] pick
);

   logic [N_REQ-1:0] eff;

   always_comb begin
      pick = '0;
      eff  = req & ~mask;
      if (eff[REQ_MAP])
         pick[REQ_MAP] = 1'b1;
      else if (eff[REQ_ANIM])
         pick[REQ_ANIM] = 1'b1;
      else if (eff[REQ_SPRITE])
         pick[REQ_SPRITE] = 1'b1;
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates three pixel producers onto one VGA adapter write port; whole-pass ownership.
// Optional tenure limit with preemption enabled by defining ARB_HOLD_LIMIT_EN.
module vga_write_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240
`ifdef ARB_HOLD_LIMIT_EN
   ,
   parameter int unsigned HOLD_LIMIT = 4096
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       valid,
   input  logic [N_REQ*X_W-1:0]   xIn,
   input  logic [N_REQ*Y_W-1:0]   yIn,
   input  logic [N_REQ*C_W-1:0]   colourIn,
   output logic [N_REQ-1:0]       grant,
   output logic                   plot,
   output logic [X_W-1:0]         x,
   output logic [Y_W-1:0]         y,
   output logic [C_W-1:0]         colour,
   output logic                   busy,
   output logic                   preempt
);

   arb_state_t       state;
   logic [N_REQ-1:0] mask;
   logic [N_REQ-1:0] pick;
   logic [X_W-1:0]   sel_x;
   logic [Y_W-1:0]   sel_y;
   logic [C_W-1:0]   sel_c;
   logic             owner_req;
   logic             owner_valid;
   logic             in_range;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int unsigned TEN_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
   logic [TEN_W-1:0] tenure;
`else
   assign mask    = '0;
   assign preempt = 1'b0;
`endif

   prio_pick3 u_pick (
      .req  (req),
      .mask (mask),
      .pick (pick)
   );

   // grant is one-hot, so OR-ing the gated fields selects the owner's pixel
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_x = sel_x | xIn[X_W*i +: X_W];
            sel_y = sel_y | yIn[Y_W*i +: Y_W];
            sel_c = sel_c | colourIn[C_W*i +: C_W];
         end
      end
      owner_req   = |(req & grant);
      owner_valid = |(valid & grant);
      in_range    = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         busy   <= 1'b0;
         plot   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         preempt <= 1'b0;
         mask    <= '0;
         tenure  <= '0;
`endif
      end else begin
         plot <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
         preempt <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef ARB_HOLD_LIMIT_EN
               mask   <= '0;
               tenure <= '0;
`endif
               if (|pick) begin
                  grant <= pick;
                  busy  <= 1'b1;
                  state <= OWN;
               end
            end
            OWN: begin
               // the owner's last pixel is forwarded even on the cycle it releases
               if (owner_valid && in_range) begin
                  plot   <= 1'b1;
                  x      <= sel_x;
                  y      <= sel_y;
                  colour <= sel_c;
               end
               if (!owner_req) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= GAP;
               end
`ifdef ARB_HOLD_LIMIT_EN
               else if (tenure == TEN_W'(HOLD_LIMIT - 1)) begin
                  preempt <= 1'b1;
                  mask    <= grant;
                  grant   <= '0;
                  busy    <= 1'b0;
                  state   <= GAP;
               end else begin
                  tenure <= tenure + 1'b1;
               end
`endif
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
